// File: rtl/waveshaper_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | waveshaper_gen_pkg                                                 |
// | Shared types and constants for the waveshaper and its noise LFSR.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package waveshaper_gen_pkg;

  typedef enum logic [2:0] {
    MODE_OFF      = 3'd0,
    MODE_SQUARE   = 3'd1,
    MODE_SAW_UP   = 3'd2,
    MODE_TRIANGLE = 3'd3,
    MODE_SAW_DOWN = 3'd4,
    MODE_NOISE    = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fsm_t;

  // Right-shift Galois mask for taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Codes 6 and 7 behave exactly like off, so they are folded to off on entry
  function automatic mode_t norm_mode(input logic [2:0] m);
    return (m > 3'd5) ? MODE_OFF : mode_t'(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/waveshaper_gen_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wave_lfsr                                                          |
// | 16-bit Galois LFSR. next_state is the value the register takes on  |
// | an advance; reload together with advance yields the first step     |
// | from SEED in the same cycle.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wave_lfsr
  import waveshaper_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        advance,
  input  logic        reload,
  output logic [15:0] next_state
);

  logic [15:0] state;
  logic [15:0] base;

  // One Galois step from either the current state or the seed
  always_comb begin
    base       = reload ? SEED : state;
    next_state = {1'b0, base[15:1]} ^ (base[0] ? LFSR_TAPS : 16'h0000);
  end

  // State register: advance wins, otherwise a bare reload restores the seed
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= SEED;
    end else if (advance) begin
      state <= next_state;
    end else if (reload) begin
      state <= SEED;
    end
  end

endmodule
`default_nettype wire

// File: rtl/waveshaper_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | waveshaper_gen                                                     |
// | Two-stage phase-to-sample waveshaper with wrap-deferred mode and   |
// | duty changes. Optional WAVESHAPER_GEN_SIGNED_EN gives two's-       |
// | complement centred output (off stays a true zero).                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module waveshaper_gen
  import waveshaper_gen_pkg::*;
#(
  parameter int          W    = 8,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] phase_in,
  input  logic         phase_valid,
  input  logic [2:0]   mode,
  input  logic [W-1:0] duty,
  input  logic         mode_load,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  output logic [2:0]   active_mode,
  output logic         wrap
);

  logic [W-1:0] p1, last_phase, duty_act, pend_duty, eff_duty, shaped, out_val;
  logic         v1, wrap1, apply, load_idle, load_pend, lfsr_adv, lfsr_reload;
  logic [15:0]  lfsr_next;
  mode_t        act_mode, pend_mode, eff_mode;
  fsm_t         state, state_nx;

  function automatic logic [W-1:0] shape(input mode_t m, input logic [W-1:0] p,
                                         input logic [W-1:0] d, input logic [15:0] nz);
    logic [W-1:0] fold;
    fold = p[W-1] ? ~p : p;
    case (m)
      MODE_SQUARE:   shape = (p >= d) ? '1 : '0;
      MODE_SAW_UP:   shape = p;
      MODE_TRIANGLE: shape = {fold[W-2:0], 1'b0};
      MODE_SAW_DOWN: shape = ~p;
      MODE_NOISE:    shape = nz[15 -: W];
      default:       shape = '0;
    endcase
  endfunction

  // S1: capture phase/valid and flag a period wrap against the last valid phase
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      p1         <= '0;
      v1         <= 1'b0;
      wrap1      <= 1'b0;
      last_phase <= '0;
    end else begin
      p1    <= phase_in;
      v1    <= phase_valid;
      wrap1 <= phase_valid && (phase_in < last_phase);
      if (phase_valid) last_phase <= phase_in;
    end
  end

  // FSM next state plus the mode/duty that S2 uses this cycle
  always_comb begin
    state_nx  = state;
    apply     = 1'b0;
    load_idle = 1'b0;
    load_pend = 1'b0;
    eff_mode  = act_mode;
    eff_duty  = duty_act;
    case (state)
      IDLE: if (mode_load) begin
        load_idle = 1'b1;
        state_nx  = (norm_mode(mode) == MODE_OFF) ? IDLE : RUN;
      end
      RUN: if (mode_load) begin
        load_pend = 1'b1;
        state_nx  = PEND;
      end
      PEND: begin
        if (v1 && wrap1) begin
          // A load coinciding with the wrap bypasses the pending registers
          apply    = 1'b1;
          eff_mode = mode_load ? norm_mode(mode) : pend_mode;
          eff_duty = mode_load ? duty : pend_duty;
          state_nx = (eff_mode == MODE_OFF) ? IDLE : RUN;
        end else if (mode_load) begin
          load_pend = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Active and pending mode/duty registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_mode  <= MODE_OFF;
      duty_act  <= '0;
      pend_mode <= MODE_OFF;
      pend_duty <= '0;
    end else begin
      if (load_idle) begin
        act_mode <= norm_mode(mode);
        duty_act <= duty;
      end else if (apply) begin
        act_mode <= eff_mode;
        duty_act <= eff_duty;
      end
      if (load_pend) begin
        pend_mode <= norm_mode(mode);
        pend_duty <= duty;
      end else if (apply) begin
        pend_mode <= MODE_OFF;
        pend_duty <= '0;
      end
    end
  end

  // Noise source: reseeded on entry into noise, stepped once per noise sample
  always_comb begin
    lfsr_reload = (load_idle && norm_mode(mode) == MODE_NOISE) ||
                  (apply && eff_mode == MODE_NOISE && act_mode != MODE_NOISE);
    lfsr_adv    = v1 && (eff_mode == MODE_NOISE);
  end

  wave_lfsr #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .n_rst      (n_rst),
    .advance    (lfsr_adv),
    .reload     (lfsr_reload),
    .next_state (lfsr_next)
  );

  // S2 combinational shaping and output formatting
  always_comb begin
    shaped = shape(eff_mode, p1, eff_duty, lfsr_next);
`ifdef WAVESHAPER_GEN_SIGNED_EN
    out_val = (eff_mode == MODE_OFF) ? '0 : (shaped ^ {1'b1, {(W-1){1'b0}}});
`else
    out_val = shaped;
`endif
  end

  // S2 output register: sample only moves on a valid
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= v1;
      wrap         <= v1 && wrap1;
      if (v1) sample <= out_val;
    end
  end

  assign active_mode = act_mode;

endmodule
`default_nettype wire

// File: tb/tb_waveshaper_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_waveshaper_gen                                                  |
// | Self-checking bench for waveshaper_gen (W=8) with a behavioural    |
// | reference model, a triangle vector table and directed sequences.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_waveshaper_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] phase_in, duty;
  logic       phase_valid, mode_load;
  logic [2:0] mode;
  logic [7:0] sample;
  logic       sample_valid, wrap;
  logic [2:0] active_mode;

  int checks = 0;
  int errors = 0;

  waveshaper_gen #(.W(8), .SEED(SEED)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .phase_in     (phase_in),
    .phase_valid  (phase_valid),
    .mode         (mode),
    .duty         (duty),
    .mode_load    (mode_load),
    .sample       (sample),
    .sample_valid (sample_valid),
    .active_mode  (active_mode),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_last, m_pph, m_active, m_duty, m_pmode, m_pduty, e_sample;
  bit          m_pv, m_pwrap, m_has_pend, e_sv, e_wrap;
  logic [15:0] m_lfsr;

  function automatic int nm(input int md);
    return (md > 5) ? 0 : md;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Output encoding of a non-off unsigned value
  function automatic int enc(input int v);
`ifdef WAVESHAPER_GEN_SIGNED_EN
    return v ^ 'h80;
`else
    return v;
`endif
  endfunction

  function automatic int ref_shape(input int md, input int p, input int d, input logic [15:0] nz);
    int r;
    case (md)
      1: r = (p >= d) ? 255 : 0;
      2: r = p;
      3: r = (p < 128) ? 2 * p : 2 * (255 - p);
      4: r = 255 - p;
      5: r = int'(nz >> 8);
      default: r = 0;
    endcase
    return (md == 0) ? 0 : enc(r);
  endfunction

  task automatic model_reset();
    m_last = 0; m_pph = 0; m_active = 0; m_duty = 0; m_pmode = 0; m_pduty = 0;
    m_pv = 0; m_pwrap = 0; m_has_pend = 0; m_lfsr = SEED;
    e_sample = 0; e_sv = 0; e_wrap = 0;
  endtask

  // Advance the model by one clock given the inputs seen at that edge.
  // The previous cycle's valid input is the one whose sample emerges now.
  task automatic model_step(input bit v, input int ph, input bit ld, input int md, input int dt);
    int eff_m, eff_d;
    bit wev, app;
    wev   = m_pv && m_pwrap;
    eff_m = m_active;
    eff_d = m_duty;
    app   = 0;
    if (m_has_pend && wev) begin
      app   = 1;
      eff_m = ld ? nm(md) : m_pmode;
      eff_d = ld ? dt : m_pduty;
    end
    if (app && eff_m == 5 && m_active != 5) m_lfsr = SEED;
    if (m_pv) begin
      if (eff_m == 5) m_lfsr = lstep(m_lfsr);
      e_sample = ref_shape(eff_m, m_pph, eff_d, m_lfsr);
    end
    e_sv   = m_pv;
    e_wrap = wev;
    if (app) begin
      m_active = eff_m; m_duty = eff_d; m_has_pend = 0;
    end else if (ld && m_active == 0) begin
      m_active = nm(md); m_duty = dt;
      if (m_active == 5) m_lfsr = SEED;
    end else if (ld) begin
      m_pmode = nm(md); m_pduty = dt; m_has_pend = 1;
    end
    m_pwrap = v && (ph < m_last);
    m_pph   = ph;
    m_pv    = v;
    if (v) m_last = ph;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare at negedge
  task automatic cyc(input bit v, input int ph, input bit ld, input int md, input int dt);
    phase_valid = v;
    phase_in    = ph[7:0];
    mode_load   = ld;
    mode        = md[2:0];
    duty        = dt[7:0];
    @(posedge clk);
    model_step(v, ph, ld, md, dt);
    @(negedge clk);
    chk("sample", sample, e_sample);
    chk("sample_valid", sample_valid, e_sv);
    chk("wrap", wrap, e_wrap);
    chk("active_mode", active_mode, m_active);
    phase_valid = 1'b0;
    mode_load   = 1'b0;
  endtask

  typedef struct {
    int ph;
    int exp;
  } vec_t;

  vec_t tri_tab[8];

  initial begin
    int p, prevp, rp;

    tri_tab[0] = '{0, 0};    tri_tab[1] = '{127, 254};
    tri_tab[2] = '{128, 254}; tri_tab[3] = '{255, 0};
    tri_tab[4] = '{64, 128};  tri_tab[5] = '{200, 110};
    tri_tab[6] = '{1, 2};     tri_tab[7] = '{254, 2};

    n_rst = 1'b0; phase_in = 0; duty = 0; phase_valid = 0; mode_load = 0; mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sample", sample, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_active_mode", active_mode, 0);
    chk("rst_wrap", wrap, 0);
    n_rst = 1'b1;

    // Triangle from IDLE applies on the next cycle, then a full sweep
    cyc(0, 0, 1, 3, 0);
    chk("tri_active", active_mode, 3);
    for (int i = 0; i < 256; i++) cyc(1, i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    foreach (tri_tab[i]) begin
      cyc(1, tri_tab[i].ph, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("tri_table", sample, enc(tri_tab[i].exp));
    end

    // Switch to saw up at the next wrap, then request square duty 64 at phase 100
    cyc(1, 250, 1, 2, 0);
    for (int i = 251; i < 356; i++) cyc(1, i % 256, 0, 0, 0);
    prevp = -1;
    for (int i = 0; i < 227; i++) begin
      p = (100 + i) % 256;
      cyc(1, p, i == 0, 1, 64);
      if (prevp == 200) chk("saw_before_wrap", sample, enc(200));
      if (prevp == 0) begin
        chk("sq_wrap_flag", wrap, 1);
        chk("sq_phase0", sample, enc(0));
        chk("sq_active", active_mode, 1);
      end
      if (prevp == 63) chk("sq_phase63", sample, enc(0));
      if (prevp == 64) chk("sq_phase64", sample, enc(255));
      prevp = p;
    end

    // Two loads while pending: only the last (saw up) lands at the wrap
    cyc(1, 71, 1, 4, 0);
    cyc(1, 72, 1, 2, 0);
    prevp = 72;
    for (int i = 73; i < 267; i++) begin
      p = i % 256;
      cyc(1, p, 0, 0, 0);
      if (prevp == 200) chk("pend_still_square", sample, enc(255));
      if (prevp == 0) begin
        chk("pend_phase0", sample, enc(0));
        chk("pend_active", active_mode, 2);
      end
      if (prevp == 5) chk("pend_phase5", sample, enc(5));
      prevp = p;
    end

    // Back to off at a wrap, then noise from IDLE with gaps in valid
    cyc(1, 11, 1, 0, 0);
    for (int i = 12; i < 260; i++) cyc(1, i % 256, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("off_active", active_mode, 0);
    cyc(0, 0, 1, 5, 0);
    chk("noise_active", active_mode, 5);
    cyc(1, 10, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("noise_step1", sample, enc('hE2));
    cyc(0, 0, 0, 0, 0);
    chk("noise_hold", sample, enc('hE2));
    chk("noise_hold_valid", sample_valid, 0);
    cyc(1, 20, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("noise_step2", sample, enc('h71));
    cyc(0, 0, 0, 0, 0);
    cyc(1, 30, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("noise_step3", sample, enc('h38));

    // Asynchronous reset with valids in flight
    cyc(1, 40, 0, 0, 0);
    cyc(1, 41, 0, 0, 0);
    phase_valid = 1'b1;
    phase_in    = 8'd42;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_sample", sample, 0);
    chk("arst_sample_valid", sample_valid, 0);
    chk("arst_active_mode", active_mode, 0);
    chk("arst_wrap", wrap, 0);
    phase_valid = 1'b0;
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

`ifdef WAVESHAPER_GEN_SIGNED_EN
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("signed_off_zero", sample, 0);
    cyc(0, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 255, 0, 0, 0);
    chk("signed_saw0", sample, 'h80);
    cyc(0, 0, 0, 0, 0);
    chk("signed_saw255", sample, 'h7F);
`endif

    // Randomised traffic against the model
    rp = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v, ld;
      v  = ($urandom % 4) != 0;
      if (v) rp = (rp + int'($urandom_range(0, 40))) % 256;
      ld = ($urandom % 16) == 0;
      cyc(v, rp, ld, int'($urandom % 8), int'($urandom % 256));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
